// File: rtl/sequence_recorder_pkg.sv
// Shared definitions for the sequence recorder.
//  - Default address/data widths (16 x 4-bit store).
//  - FSM state encoding: IDLE=0, RECORD=1, FINISH=2.
package sequence_recorder_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECORD = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    RECORD = ST_RECORD,
    FINISH = ST_FINISH
  } state_e;

endpackage

// File: rtl/sync_ram_16x4.sv
// Storage for the recorded sequence: one write port and one registered read port.
// Ports:
//  clock        rising-edge clock for both ports
//  reset        asynchronous active-low; clears only the read register
//  we/waddr/wdata  synchronous write
//  raddr        read address, sampled every edge
//  rdata        registered read data (latency 1). A read of the address being
//               written on the same edge returns the previous contents.
// Array contents are never cleared.
module sync_ram_16x4
  import sequence_recorder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

  // No reset on the array so it maps onto block/distributed RAM.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Array read happens in the same delta as the write above, so a colliding
  // read sees the old word.
  always_comb rdata_d = mem[raddr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sequence_recorder.sv
// Records a user-entered sequence of values into on-chip RAM, one per
// write_en strobe, with a ROM-compatible registered read port for replay.
// Ports:
//  clock, reset         rising-edge clock, async active-low reset
//  start, stop          1-cycle pulses: begin take / end take early
//  write_en, data_in    store data_in while recording
//  rd_address, data_out replay read port, latency 1
//  count                values recorded in current/last take (0..2**ADDR_WIDTH)
//  recording            high while in RECORD
//  full                 count at capacity
//  done                 1-cycle pulse when a take ends
// Build option: REC_OVERWRITE_EN -- when defined, a full take keeps
// recording, wrapping the write pointer over the oldest entries; count
// saturates and only stop/start/reset end the take.
module sequence_recorder
  import sequence_recorder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  recording,
  output logic                  full,
  output logic                  done
);

  localparam int                CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]     DEPTH = CW'(1 << ADDR_WIDTH);

  state_e                  state_d, state_q;
  logic [ADDR_WIDTH-1:0]   wr_ptr_d, wr_ptr_q;
  logic [CW-1:0]           count_d, count_q;
  logic                    recording_d, recording_q;
  logic                    done_d, done_q;
  logic                    ram_we;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ram_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RECORD;
          wr_ptr_d = '0;
          count_d  = '0;
        end
      end
      RECORD: begin
        // start restarts the take and masks write_en/stop this cycle
        if (start) begin
          wr_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (write_en) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = (count_q == DEPTH) ? count_q : count_q + CW'(1);
`ifndef REC_OVERWRITE_EN
            if (count_q == DEPTH - CW'(1)) state_d = FINISH;
`endif
          end
          // write+stop together: the value is still stored above
          if (stop) state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are registered so they line up with the state they describe
    recording_d = (state_d == RECORD);
    done_d      = (state_d == FINISH);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      recording_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      recording_q <= recording_d;
      done_q      <= done_d;
    end
  end

  sync_ram_16x4 #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_address),
    .rdata (data_out)
  );

  assign count     = count_q;
  assign recording = recording_q;
  assign done      = done_q;
  assign full      = (count_q == DEPTH);

endmodule

// File: tb/tb_sequence_recorder.sv
module tb_sequence_recorder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, stop = 1'b0, write_en = 1'b0;
  logic [3:0] data_in = '0, rd_address = '0;
  logic [3:0] data_out;
  logic [4:0] count;
  logic       recording, full, done;

  int checks = 0;
  int failures = 0;

  sequence_recorder dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .write_en(write_en), .data_in(data_in), .rd_address(rd_address),
    .data_out(data_out), .count(count), .recording(recording),
    .full(full), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // reference memory, filled only where the bench knows a write lands
  logic [3:0] mmem [16];
  bit         mvalid [16];

  typedef struct { logic [3:0] addr; logic [3:0] data; } rd_item_t;
  rd_item_t sb[$];

  typedef struct {
    logic s, p, w; logic [3:0] d;
    logic wr; logic [3:0] wa;
    logic [4:0] c; logic r, f, dn;
  } vec_t;
  vec_t vecs [23];

  function automatic vec_t mk(logic s, p, w, logic [3:0] d, logic wr, logic [3:0] wa,
                              logic [4:0] c, logic r, f, dn);
    vec_t v;
    v.s = s; v.p = p; v.w = w; v.d = d; v.wr = wr; v.wa = wa;
    v.c = c; v.r = r; v.f = f; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // one cycle: drive inputs, push expected read data, sample #1 after edge
  task automatic drive(input logic s, input logic p, input logic w, input logic [3:0] d,
                       input logic wr, input logic [3:0] wa, input logic [3:0] ra);
    rd_item_t it;
    bit pend;
    start = s; stop = p; write_en = w; data_in = d; rd_address = ra;
    pend = mvalid[ra];
    if (pend) sb.push_back('{addr: ra, data: mmem[ra]});
    @(posedge clock); #1;
    if (wr) begin mmem[wa] = d; mvalid[wa] = 1'b1; end
    if (pend) begin
      it = sb.pop_front();
      chk($sformatf("rd_data[%0d]", it.addr), data_out, it.data);
    end
    start = 0; stop = 0; write_en = 0;
  endtask

  task automatic outs(input string tag, input logic [4:0] c, input logic r,
                      input logic f, input logic dn);
    chk({tag, ".count"}, count, c);
    chk({tag, ".recording"}, recording, r);
    chk({tag, ".full"}, full, f);
    chk({tag, ".done"}, done, dn);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mmem[i] = '0; mvalid[i] = 1'b0; end

    //           s p w d     wr wa    c  r f dn
    vecs[0]  = mk(1,0,0,4'h0, 0,4'h0, 0, 1,0,0); // take 1
    vecs[1]  = mk(0,0,1,4'h3, 1,4'h0, 1, 1,0,0);
    vecs[2]  = mk(0,0,1,4'h7, 1,4'h1, 2, 1,0,0);
    vecs[3]  = mk(0,0,1,4'hA, 1,4'h2, 3, 1,0,0);
    vecs[4]  = mk(0,1,0,4'h0, 0,4'h0, 3, 0,0,1);
    vecs[5]  = mk(0,0,0,4'h0, 0,4'h0, 3, 0,0,0);
    vecs[6]  = mk(0,1,1,4'h9, 0,4'h0, 3, 0,0,0); // idle: write/stop ignored
    vecs[7]  = mk(1,0,0,4'h0, 0,4'h0, 0, 1,0,0); // write+stop same cycle
    vecs[8]  = mk(0,0,1,4'h1, 1,4'h0, 1, 1,0,0);
    vecs[9]  = mk(0,0,1,4'h4, 1,4'h1, 2, 1,0,0);
    vecs[10] = mk(0,1,1,4'h5, 1,4'h2, 3, 0,0,1);
    vecs[11] = mk(0,0,0,4'h0, 0,4'h0, 3, 0,0,0);
    vecs[12] = mk(1,0,0,4'h0, 0,4'h0, 0, 1,0,0); // restart mid-take
    vecs[13] = mk(0,0,1,4'h8, 1,4'h0, 1, 1,0,0);
    vecs[14] = mk(0,0,1,4'h9, 1,4'h1, 2, 1,0,0);
    vecs[15] = mk(0,0,1,4'hB, 1,4'h2, 3, 1,0,0);
    vecs[16] = mk(0,0,1,4'hC, 1,4'h3, 4, 1,0,0);
    vecs[17] = mk(1,0,0,4'h0, 0,4'h0, 0, 1,0,0);
    vecs[18] = mk(0,0,1,4'hD, 1,4'h0, 1, 1,0,0);
    vecs[19] = mk(1,0,1,4'hF, 0,4'h0, 0, 1,0,0); // start beats write_en
    vecs[20] = mk(0,1,0,4'h0, 0,4'h0, 0, 0,0,1);
    vecs[21] = mk(0,0,0,4'h0, 0,4'h0, 0, 0,0,0);
    vecs[22] = mk(0,0,0,4'h0, 0,4'h0, 0, 0,0,0);

    // reset state
    #12;
    outs("reset", 5'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.data_out", data_out, 4'h0);
    @(negedge clock) reset = 1'b1;

    // table: basic take, write+stop, restart, start priority; reads
    // cycle through addresses 0..3 including same-edge collisions
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].s, vecs[i].p, vecs[i].w, vecs[i].d, vecs[i].wr, vecs[i].wa, 4'(i % 4));
      outs($sformatf("vec%0d", i), vecs[i].c, vecs[i].r, vecs[i].f, vecs[i].dn);
    end
    for (int a = 0; a < 4; a++) drive(0,0,0,4'h0, 0,4'h0, 4'(a));

`ifndef REC_OVERWRITE_EN
    // 16 writes end the take without stop
    drive(1,0,0,4'h0, 0,4'h0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      drive(0,0,1,4'(i), 1,4'(i), 4'h0);
      if (i < 15) outs($sformatf("fill%0d", i), 5'(i + 1), 1'b1, 1'b0, 1'b0);
    end
    outs("fill_end", 5'd16, 1'b0, 1'b1, 1'b1);
    drive(0,0,0,4'h0, 0,4'h0, 4'h0);
    outs("fill_idle", 5'd16, 1'b0, 1'b1, 1'b0);
    drive(0,0,1,4'h7, 0,4'h0, 4'h0);               // ignored in IDLE
    outs("fill_17th", 5'd16, 1'b0, 1'b1, 1'b0);
    for (int a = 0; a < 16; a++) drive(0,0,0,4'h0, 0,4'h0, 4'(a));
`endif

    // reset mid-take at count 6
    drive(1,0,0,4'h0, 0,4'h0, 4'h0);
    outs("mid_start", 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(0,0,1,4'(i + 9), 1,4'(i), 4'h0);
    outs("mid_pre", 5'd6, 1'b1, 1'b0, 1'b0);
    drive(0,0,0,4'h0, 0,4'h0, 4'h0);
    chk("mid_pre.data_out", data_out, 4'h9);
    #2 reset = 1'b0;
    #1;
    outs("mid_rst", 5'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst.data_out", data_out, 4'h0);
    @(negedge clock) reset = 1'b1;
    for (int a = 0; a < 6; a++) drive(0,0,0,4'h0, 0,4'h0, 4'(a));

`ifdef REC_OVERWRITE_EN
    // full take keeps recording and wraps over the oldest entries
    drive(1,0,0,4'h0, 0,4'h0, 4'h0);
    for (int i = 0; i < 18; i++) begin
      drive(0,0,1,4'(i), 1,4'(i % 16), 4'h5);
      if (i == 15) outs("ow16", 5'd16, 1'b1, 1'b1, 1'b0);
    end
    outs("ow18", 5'd16, 1'b1, 1'b1, 1'b0);
    drive(0,1,0,4'h0, 0,4'h0, 4'h0);
    outs("ow_stop", 5'd16, 1'b0, 1'b1, 1'b1);
    chk("ow.mem0", mmem[0], 4'h0);
    chk("ow.mem1", mmem[1], 4'h1);
    for (int a = 0; a < 3; a++) drive(0,0,0,4'h0, 0,4'h0, 4'(a));
`endif

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
